// File: rtl/feat_mem_pkg.sv
// Shared definitions for the ping-pong feature buffer: bank identifiers,
// lane/address width helpers and the read-latency legality check.
package feat_mem_pkg;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int lanes(input int word_w, input int elem_w);
    return word_w / elem_w;
  endfunction

  function automatic int lane_aw(input int word_w, input int elem_w);
    return $clog2(word_w / elem_w);
  endfunction

  function automatic int word_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int elem_aw(input int depth, input int word_w, input int elem_w);
    return $clog2(depth) + $clog2(word_w / elem_w);
  endfunction

  function automatic bit rd_lat_ok(input int rd_lat);
    return (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

  function automatic bank_t flip(input bank_t b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/feat_bank_ram.sv
// One feature bank: DEPTH x WORD_W synchronous RAM, per-lane write enable,
// registered read port. Contents are intentionally not reset.
module feat_bank_ram
  import feat_mem_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 256,
  localparam int LANES = WORD_W / ELEM_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[waddr][i*ELEM_W +: ELEM_W] <= wdata[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/feat_pp_ram.sv
// Double-buffered feature RAM: producer fills one bank with word writes while
// the consumer reads single elements from the other; done pulses swap ownership.
module feat_pp_ram
  import feat_mem_pkg::*;
#(
  parameter int  WORD_W  = 32,
  parameter int  ELEM_W  = 8,
  parameter int  DEPTH   = 256,
  parameter int  RD_LAT  = 2,
  localparam int LANES   = lanes(WORD_W, ELEM_W),
  localparam int LANE_AW = lane_aw(WORD_W, ELEM_W),
  localparam int WORD_AW = word_aw(DEPTH),
  localparam int ELEM_AW = elem_aw(DEPTH, WORD_W, ELEM_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LANES-1:0]   wr_en,
  input  logic [WORD_AW-1:0] wr_addr,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               wr_done,
  output logic               wr_ready,
  input  logic               rd_en,
  input  logic [ELEM_AW-1:0] rd_addr,
  input  logic               rd_done,
  output logic               rd_ready,
  output logic [ELEM_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic [1:0]         full_cnt,
  output logic               err_ovf,
  output logic               err_udf
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("feat_pp_ram: RD_LAT must be 1 or 2");
  end

  bank_t               wr_bank;
  bank_t               rd_bank;
  bank_t               s1_bank;
  logic                s1_valid;
  logic [LANE_AW-1:0]  s1_lane;
  logic [ELEM_W-1:0]   data_reg;
  logic [WORD_W-1:0]   bank_rdata [2];
  logic [ELEM_W-1:0]   lane_elem [LANES];
  logic [WORD_W-1:0]   sel_word;
  logic [ELEM_W-1:0]   elem;
  logic                wr_acc;
  logic                rd_acc;
  logic                issue;

  assign wr_ready = (full_cnt != 2'd2);
  assign rd_ready = (full_cnt != 2'd0);
  assign wr_acc   = wr_done && wr_ready;
  assign rd_acc   = rd_done && rd_ready;
  assign issue    = rd_en && rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= BANK0;
      rd_bank  <= BANK0;
      full_cnt <= 2'd0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      if (wr_acc) wr_bank <= flip(wr_bank);
      if (rd_acc) rd_bank <= flip(rd_bank);
      if (wr_acc && !rd_acc) full_cnt <= full_cnt + 2'd1;
      else if (rd_acc && !wr_acc) full_cnt <= full_cnt - 2'd1;
      if (!wr_ready && (wr_done || (|wr_en))) err_ovf <= 1'b1;
      if (!rd_ready && (rd_done || rd_en)) err_udf <= 1'b1;
    end
  end

  // Bank ownership gating: each bank sees writes or reads only while it owns that role.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam bank_t ID = (gi == 0) ? BANK0 : BANK1;
    feat_bank_ram #(
      .WORD_W (WORD_W),
      .ELEM_W (ELEM_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk   (clk),
      .we    ((wr_ready && (wr_bank == ID)) ? wr_en : '0),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (issue && (rd_bank == ID)),
      .raddr (rd_addr[ELEM_AW-1:LANE_AW]),
      .rdata (bank_rdata[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_bank  <= BANK0;
      s1_lane  <= '0;
    end else begin
      s1_valid <= issue;
      s1_bank  <= rd_bank;
      s1_lane  <= rd_addr[LANE_AW-1:0];
    end
  end

  assign sel_word = bank_rdata[s1_bank];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_elem[gi] = sel_word[gi*ELEM_W +: ELEM_W];
  end

  assign elem = lane_elem[s1_lane];

  // data_reg doubles as the hold register for rd_data between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (s1_valid) begin
      data_reg <= elem;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_data  = s1_valid ? elem : data_reg;
  end else begin : g_lat2
    logic out_valid;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_valid <= 1'b0;
      else        out_valid <= s1_valid;
    end
    assign rd_valid = out_valid;
    assign rd_data  = data_reg;
  end

endmodule

// File: doc/feat_pp_ram.md
Name: feat_pp_ram

Overview:
Parametrised, double-buffered (ping-pong) feature buffer for the conv layers; the next generation of the per-layer feature RAMs. A producer (DMA or previous layer) fills one bank with byte-enabled word writes while the conv engine reads the other bank one byte-lane element at a time. Bank ownership is exchanged by a done/ready handshake, so a layer can stream its next input tile while the current tile is processed.

Parameters:
WORD_W, 32, write word width in bits; multiple of ELEM_W.
ELEM_W, 8, read element width in bits.
DEPTH, 256, words per bank; power of two.
RD_LAT, 2, read latency in cycles; legal values 1 and 2 only.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  WORD_W/ELEM_W  per-lane write enable into the current write bank.
wr_addr  in  log2(DEPTH)  word address.
wr_data  in  WORD_W  write data; lane 0 = bits [ELEM_W-1:0].
wr_done  in  1  pulse: producer has finished filling the write bank.
wr_ready  out  1  a write bank is free.
rd_en  in  1  read request from the current read bank.
rd_addr  in  log2(DEPTH*WORD_W/ELEM_W)  element address; upper bits = word, lower bits = lane.
rd_done  in  1  pulse: consumer has finished with the read bank.
rd_ready  out  1  a filled bank is available.
rd_data  out  ELEM_W  read element.
rd_valid  out  1  rd_data is valid this cycle.
full_cnt  out  2  number of filled banks (0..2).
err_ovf  out  1  sticky: wr_done or write while !wr_ready.
err_udf  out  1  sticky: rd_done or rd_en while !rd_ready.

Behaviour:
- Reset (async assert, sync deassert by the reset tree): wr_bank=0, rd_bank=0, full_cnt=0, wr_ready=1, rd_ready=0, rd_valid=0, rd_data=0, err_ovf=0, err_udf=0. RAM contents are not reset and are undefined.
- wr_ready = (full_cnt != 2); rd_ready = (full_cnt != 0); both are combinational from registered state.
- Write: when wr_ready is high, each lane i with wr_en[i]=1 is written at wr_addr of wr_bank on the clock edge. When wr_ready is low, the write is dropped and err_ovf is set.
- wr_done with wr_ready high: wr_bank toggles and full_cnt increments. wr_done with wr_ready low: ignored and err_ovf is set.
- A write and wr_done in the same cycle: the write lands in the old bank, then the bank toggles.
- Read: rd_en with rd_ready high issues a read of rd_bank. At issue the block captures the bank index and the lane select.
  - rd_valid is high exactly RD_LAT cycles after issue, with rd_data = the selected lane.
  - RD_LAT=1: registered RAM output only. RD_LAT=2: an additional output register.
  - Back-to-back reads are fully pipelined at one per cycle.
- rd_en with rd_ready low: no read, rd_valid stays 0, err_udf is set.
- rd_done with rd_ready high: rd_bank toggles and full_cnt decrements. rd_done with rd_ready low: ignored and err_udf is set.
- rd_en and rd_done in the same cycle: the read completes from the old bank. Reads already in flight are unaffected by later bank toggles.
- Simultaneous valid wr_done and rd_done: full_cnt is unchanged and both bank pointers toggle.
- No read/write collision is possible. wr_bank and rd_bank differ whenever full_cnt=1; reads are blocked at full_cnt=0; writes are blocked at full_cnt=2.
- When rd_valid=0, rd_data holds its last value.
- Asserting rst_n low mid-operation: in-flight reads are discarded (rd_valid=0 immediately) and all handshake state returns to reset values.
- Address width rules: lane select = rd_addr[log2(WORD_W/ELEM_W)-1:0]; word index = the remaining upper bits. There is no wrap beyond DEPTH because addresses are exactly sized.

Decomposition:
- Shared package (feat_mem_pkg): lane count, address-width functions (clog2-based), and the RD_LAT legality check constant.
- One sub-module, feat_bank_ram: single-port-write / single-port-read synchronous RAM of DEPTH x WORD_W with per-lane write enable and a registered output.
  - It is instantiated twice, once per bank.
  - The top holds the ping-pong control, the lane mux, and the latency pipeline.

Test Plan:
- Reset, then write words 0..255 of bank 0 with data {a+3,a+2,a+1,a} per lane and wr_en=4'hF, then wr_done -> full_cnt=1, rd_ready=1, wr_ready=1. Then rd_addr=0x005 -> rd_valid two cycles later with rd_data=0x05.
- Fill both banks (bank1 data = bank0 data XOR 0xFF), then wr_done again -> full_cnt=2, wr_ready=0, err_ovf=1. A further write with wr_en=4'hF leaves bank 0 unchanged on readback.
- Partial byte-lane write: write 0xAABBCCDD to word 3 with wr_en=4'b0101 over 0x00000000 -> element reads 12..15 return DD,00,BB,00.
- Streamed reads rd_addr 0..7 on consecutive cycles, with rd_done asserted alongside the last rd_en -> eight consecutive rd_valid cycles of data 0..7 from the old bank, then rd_bank toggles.
- With full_cnt=1, assert wr_done and rd_done in the same cycle -> full_cnt stays 1, both pointers toggle, and the next reads return bank 1 data.
- Issue a read, assert rst_n=0 one cycle later -> rd_valid=0, full_cnt=0, err flags cleared. After release, rd_en -> no rd_valid and err_udf=1. Repeat the whole plan with RD_LAT=1 and the latency checks reduced to one cycle.
